// File: rtl/linear_seq_ctrl.sv
// rtl/linear_seq_ctrl.sv - Sequencer feeding a fully connected layer and picking the argmax class
//
// Purpose: on start, streams N_IN features from a feature buffer into an
// external FC layer, waits (bounded by TIMEOUT) for the FC result, then scans
// the N_OUT signed class sums one per cycle and reports the winner.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  request one inference (honoured only when idle)
//   feat_pause             suspends feature reads while feeding
//   feat_rd_en/addr/data   feature buffer read port (data one cycle after en)
//   lin_data_in/_valid     feature stream into the FC layer
//   lin_data_out/_valid    packed signed FC sums, class k at [32k+31:32k]
//   busy                   high whenever not idle
//   done                   one-cycle pulse with class_id/class_score valid
//   class_id, class_score  argmax index and its signed score
//   err_timeout            sticky: FC result not seen in time

module linear_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int N_IN       = 75,
    parameter int N_OUT      = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  feat_pause,
    output logic                  feat_rd_en,
    output logic [6:0]            feat_rd_addr,
    input  logic [DATA_WIDTH-1:0] feat_rd_data,
    output logic [DATA_WIDTH-1:0] lin_data_in,
    output logic                  lin_data_in_valid,
    input  logic [32*N_OUT-1:0]   lin_data_out,
    input  logic                  lin_data_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            class_id,
    output logic [31:0]           class_score,
    output logic                  err_timeout
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t             state;
    logic [6:0]         rd_cnt;
    logic [WW-1:0]      wait_cnt;
    logic [1:0]         am_idx;
    logic [1:0]         best_idx;
    logic signed [31:0] best_score;
    logic signed [31:0] score [N_OUT];

    logic signed [31:0] cur_score;
    logic               take;
    logic [1:0]         nxt_idx;
    logic signed [31:0] nxt_score;

    // Buffer data arrives one cycle after the strobe, so the registered
    // strobe qualifies the raw read data directly.
    assign lin_data_in = lin_data_in_valid ? feat_rd_data : '0;

    // Strict greater-than keeps the earliest index on ties; the first class
    // always seeds the running best.
    always_comb begin
        cur_score = score[am_idx];
        take      = (am_idx == 2'd0) || (cur_score > best_score);
        nxt_idx   = take ? am_idx : best_idx;
        nxt_score = take ? cur_score : best_score;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            rd_cnt            <= '0;
            wait_cnt          <= '0;
            am_idx            <= '0;
            best_idx          <= '0;
            best_score        <= '0;
            for (int k = 0; k < N_OUT; k++) score[k] <= '0;
            feat_rd_en        <= 1'b0;
            feat_rd_addr      <= '0;
            lin_data_in_valid <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            class_id          <= '0;
            class_score       <= '0;
            err_timeout       <= 1'b0;
        end else begin
            done              <= 1'b0;
            feat_rd_en        <= 1'b0;
            lin_data_in_valid <= feat_rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_FEED;
                        rd_cnt      <= '0;
                        busy        <= 1'b1;
                        err_timeout <= 1'b0;
                    end
                end
                S_FEED: begin
                    if (!feat_pause) begin
                        feat_rd_en   <= 1'b1;
                        feat_rd_addr <= rd_cnt;
                        rd_cnt       <= rd_cnt + 7'd1;
                        if (rd_cnt == 7'(N_IN - 1)) begin
                            state    <= S_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (lin_data_out_valid) begin
                        for (int k = 0; k < N_OUT; k++)
                            score[k] <= lin_data_out[32*k +: 32];
                        am_idx <= '0;
                        state  <= S_ARGMAX;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    best_idx   <= nxt_idx;
                    best_score <= nxt_score;
                    if (am_idx == 2'(N_OUT - 1)) begin
                        class_id    <= nxt_idx;
                        class_score <= nxt_score;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        am_idx <= am_idx + 2'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linear_seq_ctrl.sv
// tb/tb_linear_seq_ctrl.sv - Scoreboard bench for linear_seq_ctrl with feature buffer and FC layer models

module tb_linear_seq_ctrl;

    localparam int DW      = 16;
    localparam int N_IN    = 75;
    localparam int N_OUT   = 3;
    localparam int TIMEOUT = 15;
    localparam int NOM_LAT = N_IN + 1 + 3 + 1 + N_OUT + 1;
    localparam int WAIT_AT = N_IN + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 feat_pause = 1'b0;
    logic                 feat_rd_en;
    logic [6:0]           feat_rd_addr;
    logic [DW-1:0]        feat_rd_data;
    logic [DW-1:0]        lin_data_in;
    logic                 lin_data_in_valid;
    logic [32*N_OUT-1:0]  lin_data_out;
    logic                 lin_data_out_valid;
    logic                 busy, done;
    logic [1:0]           class_id;
    logic [31:0]          class_score;
    logic                 err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mem [N_IN];
    int            w [N_OUT][N_IN];
    int            fc_mode = 0;        // 0 compute, 1 forced scores, 2 never answer
    int            forced [N_OUT];
    bit            pat [256];

    typedef struct {
        int id;
        int sc;
        bit tmo;
        int at;
    } exp_t;
    exp_t sb [$];

    linear_seq_ctrl #(
        .DATA_WIDTH(DW), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .feat_pause(feat_pause),
        .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
        .lin_data_in(lin_data_in), .lin_data_in_valid(lin_data_in_valid),
        .lin_data_out(lin_data_out), .lin_data_out_valid(lin_data_out_valid),
        .busy(busy), .done(done), .class_id(class_id), .class_score(class_score),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Feature buffer: data one cycle after the read strobe, junk otherwise.
    always @(posedge clk) feat_rd_data <= feat_rd_en ? mem[feat_rd_addr] : DW'($urandom);

    // FC layer stand-in: accumulates the streamed features, answers 3 cycles
    // after the last valid input.
    int               acc [N_OUT];
    int               n_in;
    logic [1:0]       pend;
    logic             fc_valid;
    logic [32*N_OUT-1:0] result;
    logic             fc_last;
    logic             stray = 1'b0;
    logic [32*N_OUT-1:0] stray_data = '0;

    assign fc_last            = lin_data_in_valid && (n_in == N_IN - 1);
    assign lin_data_out       = stray ? stray_data : result;
    assign lin_data_out_valid = fc_valid | stray;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_in     <= 0;
            pend     <= '0;
            fc_valid <= 1'b0;
            result   <= '0;
            for (int k = 0; k < N_OUT; k++) acc[k] <= 0;
        end else begin
            fc_valid <= pend[1] && (fc_mode != 2);
            pend     <= {pend[0], fc_last};
            if (lin_data_in_valid) begin
                n_in <= fc_last ? 0 : n_in + 1;
                for (int k = 0; k < N_OUT; k++) begin
                    if (fc_last) begin
                        result[32*k +: 32] <= (fc_mode == 1) ? forced[k]
                                            : acc[k] + $signed(lin_data_in) * w[k][n_in];
                        acc[k] <= 0;
                    end else begin
                        acc[k] <= acc[k] + $signed(lin_data_in) * w[k][n_in];
                    end
                end
            end
        end
    end

    // Reference: class sums from plain dot products, winner by a linear scan
    // that only replaces on a strictly larger value.
    function automatic void ref_model(output int id, output int sc);
        int s [N_OUT];
        for (int k = 0; k < N_OUT; k++) begin
            s[k] = 0;
            if (fc_mode == 1) s[k] = forced[k];
            else for (int i = 0; i < N_IN; i++) s[k] += $signed(mem[i]) * w[k][i];
        end
        id = 0;
        for (int k = 1; k < N_OUT; k++) if (s[k] > s[id]) id = k;
        sc = s[id];
    endfunction

    // Pause cycles spent before the last of the N_IN reads is issued.
    function automatic int paused_cycles();
        int ok = 0;
        int p  = 0;
        for (int j = 0; j < 256 && ok < N_IN; j++) begin
            if (pat[j]) p++;
            else ok++;
        end
        return p;
    endfunction

    int start_cyc = -1000;
    int pk;
    always begin
        @(posedge clk);
        #2;
        pk = cyc - start_cyc - 1;
        feat_pause = (pk >= 0 && pk < 256) ? pat[pk] : 1'b0;
    end

    // Monitor / scoreboard.
    int   exp_addr = 0;
    int   exp_din  = 0;
    int   reads    = 0;
    int   n_done   = 0;
    int   last_id  = 0;
    int   last_sc  = 0;
    logic err_q    = 1'b0;
    logic done_q   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   id, sc;
        if (!rst_n) begin
            sb.delete();
            exp_addr = 0;
            exp_din  = 0;
            reads    = 0;
        end else begin
            if (start && !busy) begin
                ref_model(id, sc);
                e.id  = id;
                e.sc  = sc;
                e.tmo = (fc_mode == 2);
                e.at  = cyc + (e.tmo ? WAIT_AT + TIMEOUT : NOM_LAT) + paused_cycles();
                sb.push_back(e);
                start_cyc = cyc;
                reads     = 0;
            end
            if (feat_rd_en) begin
                chk("rd_addr", feat_rd_addr, exp_addr);
                exp_addr = (exp_addr + 1) % N_IN;
                reads++;
            end
            if (lin_data_in_valid) begin
                chk("lin_data_in", lin_data_in, mem[exp_din]);
                exp_din = (exp_din + 1) % N_IN;
            end else begin
                chk("lin_data_in_zero", lin_data_in, 0);
            end
            if (done) begin
                n_done++;
                chk("done_pulse", done_q, 0);
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_vs_timeout", 0, e.tmo);
                    chk("class_id", class_id, e.id);
                    chk("class_score", $signed(class_score), e.sc);
                    chk("done_cycle", cyc, e.at);
                    chk("reads", reads, N_IN);
                    chk("err_low_at_done", err_timeout, 0);
                    last_id = e.id;
                    last_sc = e.sc;
                end
            end
            if (err_timeout && !err_q) begin
                if (sb.size() == 0) begin
                    chk("timeout_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("timeout_vs_done", 1, e.tmo);
                    chk("timeout_cycle", cyc, e.at);
                    chk("busy_at_timeout", busy, 0);
                    chk("hold_class_id", class_id, last_id);
                    chk("hold_class_score", $signed(class_score), last_sc);
                end
            end
        end
        err_q  = err_timeout;
        done_q = done;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || sb.size() != 0) && n < bound) begin
            tick(1);
            n++;
        end
        chk("wait_idle_in_time", (n < bound), 1);
        tick(1);
    endtask

    task automatic run_one();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(400);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_feat_rd_en"}, feat_rd_en, 0);
        chk({tag, "_feat_rd_addr"}, feat_rd_addr, 0);
        chk({tag, "_lin_valid"}, lin_data_in_valid, 0);
        chk({tag, "_lin_data_in"}, lin_data_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_class_id"}, class_id, 0);
        chk({tag, "_class_score"}, class_score, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic rand_weights();
        for (int k = 0; k < N_OUT; k++)
            for (int i = 0; i < N_IN; i++) w[k][i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        int n, base, r;
        for (int j = 0; j < 256; j++) pat[j] = 1'b0;
        for (int i = 0; i < N_IN; i++) mem[i] = DW'(i + 1);
        rand_weights();

        // Reset state.
        tick(2);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(2);

        // Nominal inference with features index+1.
        run_one();

        // Five-cycle pause at index 30.
        for (int j = 30; j < 35; j++) pat[j] = 1'b1;
        run_one();
        for (int j = 0; j < 256; j++) pat[j] = 1'b0;

        // Forced scores: tie with signed compare, and most-negative value.
        fc_mode = 1;
        forced[0] = -5; forced[1] = -5; forced[2] = -9;
        run_one();
        forced[0] = 100; forced[1] = int'(32'h8000_0000); forced[2] = 101;
        run_one();

        // Randomized inferences with pauses, stray results and stray starts.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N_IN; i++) mem[i] = DW'($urandom);
            rand_weights();
            for (int j = 0; j < 256; j++) pat[j] = ($urandom_range(0, 4) == 0);
            fc_mode = int'($urandom_range(0, 1));
            for (int k = 0; k < N_OUT; k++) forced[k] = int'($urandom_range(0, 3)) - 2;
            if (it % 3 == 0) forced[k_hi()] = int'($urandom);
            start = 1'b1;
            tick(1);
            start = 1'b0;
            r = int'($urandom_range(3, 40));
            tick(r);
            stray      = 1'b1;
            stray_data = {$urandom, $urandom, $urandom};
            start      = 1'b1;
            tick(1);
            stray = 1'b0;
            start = 1'b0;
            wait_idle(400);
            stray      = 1'b1;
            stray_data = {$urandom, $urandom, $urandom};
            tick(1);
            stray = 1'b0;
        end
        for (int j = 0; j < 256; j++) pat[j] = 1'b0;

        // FC layer never answers: timeout, sticky error, cleared by start.
        fc_mode = 2;
        run_one();
        tick(5);
        @(negedge clk);
        chk("err_sticky", err_timeout, 1);
        chk("busy_after_timeout", busy, 0);
        @(posedge clk);
        #2;
        fc_mode = 0;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_start", err_timeout, 0);
        wait_idle(400);

        // Start held high: back-to-back runs.
        base  = n_done;
        n     = 0;
        start = 1'b1;
        while (n_done < base + 3 && n < 600) begin
            tick(1);
            n++;
        end
        start = 1'b0;
        chk("back_to_back_runs", n_done - base >= 3, 1);
        wait_idle(400);

        // Reset at feature index 40, then a full inference.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (!(feat_rd_en && feat_rd_addr == 7'd40) && n < 200) begin
            tick(1);
            n++;
        end
        chk("reached_index_40", (n < 200), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_reset_lin_valid", lin_data_in_valid, 0);
            chk("post_reset_busy", busy, 0);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < N_IN; i++) mem[i] = DW'(i + 1);
        run_one();

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int k_hi();
        return int'($urandom_range(0, N_OUT - 1));
    endfunction

endmodule

// File: doc/linear_seq_ctrl.md
LINEAR_SEQ_CTRL -- requirements
Module: linear_seq_ctrl

Interface
REQ-001 Parameters, one per line:
  DATA_WIDTH  16  feature width
  N_IN  75  features per inference
  N_OUT  3  class scores
  TIMEOUT  15  max cycles to wait for the result
REQ-002 Ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  request one inference; sampled in IDLE only
  feat_pause  in  1  upstream not ready; suspends feature reads
  feat_rd_en  out  1  feature buffer read strobe
  feat_rd_addr  out  7  feature index 0..N_IN-1
  feat_rd_data  in  DATA_WIDTH  buffer data; valid the cycle after feat_rd_en
  lin_data_in  out  DATA_WIDTH  feature to FC layer
  lin_data_in_valid  out  1  feature strobe to FC layer
  lin_data_out  in  32*N_OUT  packed signed sums; class k at bits [32k+31:32k]
  lin_data_out_valid  in  1  FC result strobe
  busy  out  1  high in any state except IDLE
  done  out  1  one-cycle pulse when result is valid
  class_id  out  2  argmax index
  class_score  out  32  signed score of the winning class
  err_timeout  out  1  sticky; FC result not seen within TIMEOUT
REQ-003 The clock and reset are one clock (clk) and one asynchronous, active-low reset (rst_n).

Function
REQ-004 The FSM SHALL have the states IDLE, FEED, WAIT, ARGMAX and DONE.
REQ-005 IDLE: start=1 -> FEED; rd_cnt=0; start in any other state is ignored (no queuing).
REQ-006 FEED: when feat_pause=0, assert feat_rd_en with feat_rd_addr=rd_cnt and increment rd_cnt; when feat_pause=1, feat_rd_en=0 and rd_cnt holds.
REQ-007 FEED: the cycle that issues address N_IN-1 is followed by WAIT; exactly N_IN reads per inference, addresses strictly ascending 0..N_IN-1, no repeats.
REQ-008 lin_data_in_valid SHALL equal feat_rd_en delayed one register; lin_data_in SHALL be feat_rd_data, passed through combinationally.
REQ-009 lin_data_in SHALL be 0 when lin_data_in_valid=0.
REQ-010 WAIT: wait_cnt increments each cycle from 0, starting at WAIT entry.
REQ-011 WAIT, lin_data_out_valid=1: latch all N_OUT sums into score regs; -> ARGMAX.
REQ-012 WAIT, wait_cnt reaches TIMEOUT with no lin_data_out_valid: set err_timeout; -> IDLE; no done.
REQ-013 A lin_data_out_valid outside WAIT SHALL be ignored.
REQ-014 ARGMAX: compare scores as signed 32-bit values, sequentially over one cycle per class (N_OUT cycles); -> DONE.
REQ-015 Ties SHALL go to the lowest index.
REQ-016 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-017 class_id and class_score SHALL be updated at DONE entry and hold until the next DONE.
REQ-018 Nominal latency: start to done = N_IN + 1 + 3 + 1 + N_OUT + 1 cycles when there is no pause (FC layer result delay = 3 cycles after the last valid input).
REQ-019 err_timeout is cleared only by reset or by an accepted start.
REQ-020 feat_pause asserted in WAIT, ARGMAX or DONE SHALL have no effect.

Reset
REQ-021 rst_n=0 SHALL immediately put the FSM in IDLE.
REQ-022 rst_n=0 SHALL immediately clear all outputs to 0: feat_rd_en, feat_rd_addr, lin_data_in_valid, busy, done, class_id, class_score, err_timeout.
REQ-023 rst_n=0 SHALL clear the counters and score registers.
REQ-024 A reset in mid-FEED SHALL leave no pending lin_data_in_valid after release; the FC layer is reset by the same rst_n.

Verification
REQ-025 Features = index+1, weights from the golden model, no pause -> 75 contiguous valids, done at start+84, class_id/class_score match the model.
REQ-026 Pause 5 cycles at index 30 -> addresses hold at 30, no valid gap mis-ordering, done at start+89, same result as REQ-025.
REQ-027 Scores {-5, -5, -9} -> class_id=0, class_score=-5 (tie plus signed compare); scores {100, 0x80000000, 101} -> class_id=2.
REQ-028 lin_data_out_valid forced low -> err_timeout=1 exactly TIMEOUT cycles after WAIT entry, no done, busy=0 next cycle; next start clears err_timeout.
REQ-029 start held high continuously -> back-to-back inferences, each with exactly 75 reads; start pulses during busy do not trigger extra runs.
REQ-030 rst_n low at index 40 -> all outputs 0 within the reset assertion; after release plus start, a full correct inference occurs.
